// File: rtl/dadda_pkg.sv
// Elaboration-time planning for the Dadda reduction tree: the height sequence,
// per-stage column heights and counter counts, and bit offsets of each column.
package dadda_pkg;

  localparam int MAX_STAGES = 10;
  localparam int MAX_COLS   = 128;

  localparam logic [3:0][6:0] LEGAL_WIDTHS = {7'd64, 7'd32, 7'd16, 7'd8};

  typedef logic [MAX_COLS-1:0][31:0] col_vec_t;
  typedef logic [MAX_COLS:0][31:0]   off_vec_t;

  typedef struct packed {
    logic [31:0]                  num_stages;
    logic [MAX_STAGES-1:0][31:0]  d;
  } dadda_seq_t;

  // h: column heights entering the next reduction; fa/ha: counters that reduction uses
  typedef struct packed {
    col_vec_t h;
    col_vec_t fa;
    col_vec_t ha;
  } stage_plan_t;

  function automatic logic is_legal_width(int w);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (w == int'(LEGAL_WIDTHS[i])) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic dadda_seq_t dadda_seq(int w);
    dadda_seq_t r;
    int         d;
    r = '0;
    d = 2;
    for (int k = 0; k < MAX_STAGES; k++) begin
      r.d[k] = d;
      if (d < w) r.num_stages = k + 1;
      d = (d * 3) / 2;
    end
    return r;
  endfunction

  // Heights after s reductions, plus the counters the (s+1)-th reduction places.
  function automatic stage_plan_t stage_plan(int w, int s);
    stage_plan_t p;
    col_vec_t    nh;
    dadda_seq_t  seq;
    int          d, cin, tot, excess;
    seq = dadda_seq(w);
    p   = '0;
    nh  = '0;
    d   = 0;
    for (int c = 0; c < 2*w; c++) begin
      if (c < w) p.h[c] = c + 1;
      else if (c < 2*w - 1) p.h[c] = 2*w - 1 - c;
    end
    for (int st = 0; st <= s; st++) begin
      if (st < int'(seq.num_stages)) d = int'(seq.d[int'(seq.num_stages) - 1 - st]);
      else d = 2 * w;
      cin = 0;
      for (int c = 0; c < 2*w; c++) begin
        tot    = int'(p.h[c]) + cin;
        excess = (tot > d && c < 2*w - 1) ? tot - d : 0;
        p.fa[c] = excess / 2;
        p.ha[c] = excess % 2;
        nh[c]   = tot - excess;
        cin     = excess / 2 + excess % 2;
      end
      if (st < s) p.h = nh;
    end
    return p;
  endfunction

  function automatic off_vec_t col_offsets(col_vec_t h);
    off_vec_t off;
    off = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      off[c+1] = off[c] + h[c];
    end
    return off;
  endfunction

  function automatic int carries_in(stage_plan_t p, int c);
    int n;
    n = 0;
    if (c > 0) n = int'(p.fa[c-1]) + int'(p.ha[c-1]);
    return n;
  endfunction

endpackage

// File: rtl/dadda_fa.sv
// 1-bit full adder, the 3:2 counter of the Dadda reduction tree.
module dadda_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/dadda_mult_3_2.sv
// Unsigned WIDTH x WIDTH Dadda-tree multiplier with a single registered output stage.
module dadda_mult_3_2
  import dadda_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] product
);

  localparam dadda_seq_t SEQ        = dadda_seq(WIDTH);
  localparam int         NUM_STAGES = int'(SEQ.num_stages);
  localparam int         NCOLS      = 2 * WIDTH;

  if (!is_legal_width(WIDTH)) begin : g_bad_width
    $error("dadda_mult_3_2: WIDTH must be 8, 16, 32 or 64");
  end

  logic [NCOLS-1:0] row0;
  logic [NCOLS-1:0] row1;
  logic [NCOLS-1:0] sum;

  // Each stage packs its columns back to back; within a column the order is
  // incoming carries, FA sums, HA sum, then bits passed through untouched.
  for (genvar s = 0; s <= NUM_STAGES; s++) begin : g_stage
    localparam stage_plan_t PLAN_OUT = stage_plan(WIDTH, s);
    localparam off_vec_t    OFF_OUT  = col_offsets(PLAN_OUT.h);
    localparam int          TOTAL    = int'(OFF_OUT[MAX_COLS]);

    logic [TOTAL-1:0] stage_bits;

    if (s == 0) begin : g_pp
      for (genvar c = 0; c < NCOLS; c++) begin : g_col
        localparam int IMIN = (c < WIDTH) ? 0 : c - WIDTH + 1;
        localparam int HC   = int'(PLAN_OUT.h[c]);
        localparam int OFF  = int'(OFF_OUT[c]);
        for (genvar k = 0; k < HC; k++) begin : g_bit
          assign stage_bits[OFF+k] = a[c-IMIN-k] & b[IMIN+k];
        end
      end
    end else begin : g_red
      localparam stage_plan_t PLAN_IN = stage_plan(WIDTH, s - 1);
      localparam off_vec_t    OFF_IN  = col_offsets(PLAN_IN.h);

      for (genvar c = 0; c < NCOLS; c++) begin : g_col
        localparam int HIN   = int'(PLAN_IN.h[c]);
        localparam int FA    = int'(PLAN_IN.fa[c]);
        localparam int HA    = int'(PLAN_IN.ha[c]);
        localparam int PASS  = HIN - 3*FA - 2*HA;
        localparam int IOFF  = int'(OFF_IN[c]);
        localparam int SBASE = int'(OFF_OUT[c]) + carries_in(PLAN_IN, c);
        localparam int CBASE = int'(OFF_OUT[c+1]);

        for (genvar i = 0; i < FA; i++) begin : g_fa
          dadda_fa u_fa (
            .a    (g_stage[s-1].stage_bits[IOFF+3*i]),
            .b    (g_stage[s-1].stage_bits[IOFF+3*i+1]),
            .cin  (g_stage[s-1].stage_bits[IOFF+3*i+2]),
            .s    (stage_bits[SBASE+i]),
            .cout (stage_bits[CBASE+i])
          );
        end

        if (HA > 0) begin : g_ha
          assign stage_bits[SBASE+FA] = g_stage[s-1].stage_bits[IOFF+3*FA]
                                      ^ g_stage[s-1].stage_bits[IOFF+3*FA+1];
          assign stage_bits[CBASE+FA] = g_stage[s-1].stage_bits[IOFF+3*FA]
                                      & g_stage[s-1].stage_bits[IOFF+3*FA+1];
        end

        if (PASS > 0) begin : g_pass
          assign stage_bits[SBASE+FA+HA +: PASS] =
            g_stage[s-1].stage_bits[IOFF+3*FA+2*HA +: PASS];
        end
      end
    end
  end

  localparam stage_plan_t PLAN_FIN = stage_plan(WIDTH, NUM_STAGES);
  localparam off_vec_t    OFF_FIN  = col_offsets(PLAN_FIN.h);

  // After the last reduction every column holds at most two bits.
  for (genvar c = 0; c < NCOLS; c++) begin : g_rows
    localparam int HF = int'(PLAN_FIN.h[c]);
    localparam int OF = int'(OFF_FIN[c]);
    if (HF == 0) begin : g_empty
      assign row0[c] = 1'b0;
      assign row1[c] = 1'b0;
    end else if (HF == 1) begin : g_one
      assign row0[c] = g_stage[NUM_STAGES].stage_bits[OF];
      assign row1[c] = 1'b0;
    end else begin : g_two
      assign row0[c] = g_stage[NUM_STAGES].stage_bits[OF];
      assign row1[c] = g_stage[NUM_STAGES].stage_bits[OF+1];
    end
  end

  assign sum = row0 + row1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      product   <= sum;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_dadda_mult_3_2.sv
// Directed and random checks of dadda_mult_3_2 at WIDTH 8, 16, 32 and 64 in parallel.
module tb_dadda_mult_3_2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic         v8, v16, v32, v64;
  logic [7:0]   a8, b8;
  logic [15:0]  a16, b16;
  logic [31:0]  a32, b32;
  logic [63:0]  a64, b64;
  logic         ov8, ov16, ov32, ov64;
  logic [15:0]  p8;
  logic [31:0]  p16;
  logic [63:0]  p32;
  logic [127:0] p64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dadda_mult_3_2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .out_valid(ov8), .product(p8));
  dadda_mult_3_2 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16),
    .out_valid(ov16), .product(p16));
  dadda_mult_3_2 #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .a(a32), .b(b32),
    .out_valid(ov32), .product(p32));
  dadda_mult_3_2 #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .a(a64), .b(b64),
    .out_valid(ov64), .product(p64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    a8 = '1;  b8 = '1;  a16 = '1; b16 = '1;
    a32 = '1; b32 = '1; a64 = '1; b64 = '1;
    v8 = 1'b1; v16 = 1'b1; v32 = 1'b1; v64 = 1'b1;
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (p8 !== 16'h0 || ov8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_w8 step %0d: product=%h out_valid=%b, expected 0/0", n, p8, ov8);
      end
      checks++;
      if (p16 !== 32'h0 || ov16 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_w16 step %0d: product=%h out_valid=%b, expected 0/0", n, p16, ov16);
      end
      checks++;
      if (p32 !== 64'h0 || ov32 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_w32 step %0d: product=%h out_valid=%b, expected 0/0", n, p32, ov32);
      end
      checks++;
      if (p64 !== 128'h0 || ov64 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_w64 step %0d: product=%h out_valid=%b, expected 0/0", n, p64, ov64);
      end
      if (n < 3) tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    a8 = '1;  b8 = '1;  a16 = '1; b16 = '1;
    a32 = '1; b32 = '1; a64 = '1; b64 = '1;
    v8 = 1'b1; v16 = 1'b1; v32 = 1'b1; v64 = 1'b1;
    tick();
    checks++;
    if (p8 !== 16'hFE01 || ov8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ones_w8: product=%h valid=%b, expected fe01/1", p8, ov8);
    end
    checks++;
    if (p16 !== 32'hFFFE_0001 || ov16 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ones_w16: product=%h valid=%b, expected fffe0001/1", p16, ov16);
    end
    checks++;
    if (p32 !== 64'hFFFF_FFFE_0000_0001 || ov32 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ones_w32: product=%h valid=%b, expected fffffffe00000001/1", p32, ov32);
    end
    checks++;
    if (p64 !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 || ov64 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ones_w64: product=%h valid=%b, expected fffffffffffffffe0000000000000001/1",
               p64, ov64);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] av [5];
    logic [15:0] bv [5];
    logic [31:0] ev [5];
    av = '{16'h8000, 16'h0001, 16'h0000, 16'h1234, 16'h00FF};
    bv = '{16'h8000, 16'hABCD, 16'h1234, 16'h0000, 16'h0101};
    ev = '{32'h4000_0000, 32'h0000_ABCD, 32'h0000_0000, 32'h0000_0000, 32'h0000_FFFF};
    v16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a16 = av[i];
      b16 = bv[i];
      tick();
      checks++;
      if (p16 !== ev[i] || ov16 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL boundary_w16 #%0d (%h*%h): product=%h valid=%b, expected %h/1",
                 i, av[i], bv[i], p16, ov16, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        vv [4];
    logic [15:0] av [4];
    logic [15:0] bv [4];
    logic [31:0] ev [4];
    vv = '{1'b1, 1'b0, 1'b1, 1'b1};
    av = '{16'h0003, 16'h0007, 16'h0100, 16'hFFFF};
    bv = '{16'h0005, 16'h0009, 16'h0100, 16'h0002};
    ev = '{32'h0000_000F, 32'h0000_003F, 32'h0001_0000, 32'h0001_FFFE};
    for (int i = 0; i < 4; i++) begin
      v16 = vv[i];
      a16 = av[i];
      b16 = bv[i];
      tick();
      checks++;
      if (ov16 !== vv[i]) begin
        errors++;
        $display("[TB] FAIL b2b_valid #%0d: out_valid=%b, expected %b", i, ov16, vv[i]);
      end
      checks++;
      if (p16 !== ev[i]) begin
        errors++;
        $display("[TB] FAIL b2b_product #%0d: product=%h, expected %h", i, p16, ev[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0]  e8;
    logic [31:0]  e16;
    logic [63:0]  e32;
    logic [127:0] e64;
    v8 = 1'b1; v16 = 1'b1; v32 = 1'b1; v64 = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      a8  = 8'($urandom);  b8  = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      a32 = $urandom;      b32 = $urandom;
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      e8  = {8'b0, a8} * {8'b0, b8};
      e16 = {16'b0, a16} * {16'b0, b16};
      e32 = {32'b0, a32} * {32'b0, b32};
      e64 = {64'b0, a64} * {64'b0, b64};
      tick();
      checks++;
      if (p8 !== e8 || ov8 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand_w8 #%0d: product=%h valid=%b, expected %h/1", i, p8, ov8, e8);
      end
      checks++;
      if (p16 !== e16 || ov16 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand_w16 #%0d: product=%h valid=%b, expected %h/1", i, p16, ov16, e16);
      end
      checks++;
      if (p32 !== e32 || ov32 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand_w32 #%0d: product=%h valid=%b, expected %h/1", i, p32, ov32, e32);
      end
      checks++;
      if (p64 !== e64 || ov64 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand_w64 #%0d: product=%h valid=%b, expected %h/1", i, p64, ov64, e64);
      end
      if (i == 5000) begin
        rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
          if (n == 0) #1;
          else tick();
          checks++;
          if (p8 !== 16'h0 || ov8 !== 1'b0 || p16 !== 32'h0 || ov16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_w8_w16 step %0d: p8=%h ov8=%b p16=%h ov16=%b, expected all 0",
                     n, p8, ov8, p16, ov16);
          end
          checks++;
          if (p32 !== 64'h0 || ov32 !== 1'b0 || p64 !== 128'h0 || ov64 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_w32_w64 step %0d: p32=%h ov32=%b p64=%h ov64=%b, expected all 0",
                     n, p32, ov32, p64, ov64);
          end
        end
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
